// File: rtl/lift_pkg.sv
// Shared types and constants for the lift car plant model.
package lift_pkg;

  typedef enum logic {
    AT_FLOOR = 1'b0,
    TRAVEL   = 1'b1
  } car_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/lift_car_model_if.sv
// Controller <-> car command/status bundle. master = controller, slave = car.
interface lift_car_model_if #(
  parameter int unsigned N_FLOORS = 12
);
  localparam int unsigned FW = $clog2(N_FLOORS);

  logic                direction;
  logic                motion;
  logic                door_open;
  logic [N_FLOORS-1:0] floor_sense;
  logic [FW-1:0]       cur_floor;
  logic                moving;
  logic                door_closed;
  logic                door_full;
  logic                fault;

  modport master (
    output direction, motion, door_open,
    input  floor_sense, cur_floor, moving, door_closed, door_full, fault
  );

  modport slave (
    input  direction, motion, door_open,
    output floor_sense, cur_floor, moving, door_closed, door_full, fault
  );
endinterface

// File: rtl/lift_door_model.sv
// Door position model: saturating up/down counter 0..DOOR_CYCLES with
// registered fully-closed / fully-open decode. Holds while en is low.
module lift_door_model #(
  parameter int unsigned DOOR_CYCLES = 4,
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          door_open,
  output logic [DW-1:0] dpos,
  output logic          door_closed,
  output logic          door_full
);

  localparam logic [DW-1:0] DMAX = DW'(DOOR_CYCLES);

  logic [DW-1:0] dpos_d, dpos_q;
  logic          door_closed_d, door_closed_q;
  logic          door_full_d, door_full_q;

  // Next door position and end-stop decode from the next position.
  always_comb begin
    dpos_d = dpos_q;
    if (en) begin
      if (door_open) begin
        if (dpos_q != DMAX) dpos_d = dpos_q + DW'(1);
      end else begin
        if (dpos_q != '0) dpos_d = dpos_q - DW'(1);
      end
    end
    door_closed_d = (dpos_d == '0);
    door_full_d   = (dpos_d == DMAX);
  end

  // Door position and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dpos_q        <= '0;
      door_closed_q <= 1'b1;
      door_full_q   <= 1'b0;
    end else begin
      dpos_q        <= dpos_d;
      door_closed_q <= door_closed_d;
      door_full_q   <= door_full_d;
    end
  end

  assign dpos        = dpos_q;
  assign door_closed = door_closed_q;
  assign door_full   = door_full_q;

endmodule

// File: rtl/lift_car_model.sv
// Plant model of one lift car: floor travel FSM with finite hop time plus
// door model. Define LIFT_MODEL_FAULT_EN to build the sticky fault flag;
// otherwise fault is tied low (interlocks are identical either way).
module lift_car_model
  import lift_pkg::*;
#(
  parameter int unsigned N_FLOORS      = 12,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned RESET_FLOOR   = 0
) (
  input logic             clk,
  input logic             reset,
  lift_car_model_if.slave car
);

  localparam int unsigned FW = $clog2(N_FLOORS);
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);

  car_state_e          state_d, state_q;
  logic [TW-1:0]       tcnt_d, tcnt_q;
  logic                dir_d, dir_q;
  logic [FW-1:0]       cur_floor_d, cur_floor_q;
  logic [N_FLOORS-1:0] floor_sense_d, floor_sense_q;
  logic                moving_d, moving_q;
  logic [DW-1:0]       dpos;
  logic                legal, depart;

  lift_door_model #(.DOOR_CYCLES(DOOR_CYCLES)) u_door (
    .clk         (clk),
    .reset       (reset),
    .en          (state_q == AT_FLOOR),
    .door_open   (car.door_open),
    .dpos        (dpos),
    .door_closed (car.door_closed),
    .door_full   (car.door_full)
  );

  // Departure interlock: door fully closed, no open request, direction legal.
  always_comb begin
    legal  = (car.direction == DIR_UP) ? (cur_floor_q != FW'(N_FLOORS - 1))
                                       : (cur_floor_q != '0);
    depart = (state_q == AT_FLOOR) && car.motion && (dpos == '0) &&
             !car.door_open && legal;
  end

  // Travel FSM next state: depart, count the hop, arrive one floor over.
  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    dir_d         = dir_q;
    cur_floor_d   = cur_floor_q;
    floor_sense_d = floor_sense_q;
    moving_d      = moving_q;
    case (state_q)
      AT_FLOOR: begin
        if (depart) begin
          state_d       = TRAVEL;
          tcnt_d        = TW'(1);
          dir_d         = car.direction;
          floor_sense_d = '0;
          moving_d      = 1'b1;
        end
      end
      TRAVEL: begin
        if (tcnt_q == TW'(TRAVEL_CYCLES)) begin
          state_d       = AT_FLOOR;
          tcnt_d        = '0;
          cur_floor_d   = (dir_q == DIR_UP) ? cur_floor_q + FW'(1)
                                            : cur_floor_q - FW'(1);
          floor_sense_d = ONE << cur_floor_d;
          moving_d      = 1'b0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = AT_FLOOR;
    endcase
  end

  // Travel FSM registers; reset snaps the car to RESET_FLOOR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= AT_FLOOR;
      tcnt_q        <= '0;
      dir_q         <= DIR_DN;
      cur_floor_q   <= FW'(RESET_FLOOR);
      floor_sense_q <= ONE << RESET_FLOOR;
      moving_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      dir_q         <= dir_d;
      cur_floor_q   <= cur_floor_d;
      floor_sense_q <= floor_sense_d;
      moving_q      <= moving_d;
    end
  end

  assign car.floor_sense = floor_sense_q;
  assign car.cur_floor   = cur_floor_q;
  assign car.moving      = moving_q;

`ifdef LIFT_MODEL_FAULT_EN
  logic fault_cond;
  logic fault_d, fault_q;

  // Protocol violations: motion blocked by open door or illegal direction,
  // or a door request while travelling.
  always_comb begin
    fault_cond = ((state_q == AT_FLOOR) && car.motion && ((dpos != '0) || !legal)) ||
                 ((state_q == TRAVEL) && car.door_open);
    fault_d    = fault_q | fault_cond;
  end

  // Sticky fault register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign car.fault = fault_q;
`else
  assign car.fault = 1'b0;
`endif

endmodule

// File: tb/tb_lift_car_model.sv
// Scoreboard bench for lift_car_model: stimulus steps a behavioural car model
// and queues the expected post-edge outputs; a monitor pops and compares.
module tb_lift_car_model;

  localparam int N  = 12;
  localparam int T  = 8;
  localparam int D  = 4;
  localparam int RF = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lift_car_model_if #(.N_FLOORS(N)) bus ();

  lift_car_model #(
    .N_FLOORS      (N),
    .TRAVEL_CYCLES (T),
    .DOOR_CYCLES   (D),
    .RESET_FLOOR   (RF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .car   (bus.slave)
  );

  typedef struct {
    logic [11:0] fs;
    logic [3:0]  cf;
    logic        mv;
    logic        dc;
    logic        df;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference car: floor number, cycles left in the current hop, door position.
  int m_floor, m_hop, m_door;
  bit m_up, m_flt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_floor = RF; m_hop = 0; m_door = 0; m_up = 0; m_flt = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.fs = (m_hop > 0) ? 12'h000 : (12'h001 << m_floor);
    e.cf = 4'(m_floor);
    e.mv = (m_hop > 0);
    e.dc = (m_door == 0);
    e.df = (m_door == D);
`ifdef LIFT_MODEL_FAULT_EN
    e.fl = m_flt;
`else
    e.fl = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_step(input bit dir, input bit mot, input bit dopen);
    bit legal;
    if (m_hop > 0) begin
      if (dopen) m_flt = 1;
      m_hop--;
      if (m_hop == 0) m_floor = m_up ? m_floor + 1 : m_floor - 1;
    end else begin
      legal = dir ? (m_floor < N - 1) : (m_floor > 0);
      if (mot && (m_door != 0 || !legal)) m_flt = 1;
      if (mot && m_door == 0 && !dopen && legal) begin
        m_hop = T;
        m_up  = dir;
      end else if (dopen) begin
        if (m_door < D) m_door++;
      end else begin
        if (m_door > 0) m_door--;
      end
    end
  endtask

  task automatic drive(input bit dir, input bit mot, input bit dopen);
    @(negedge clk);
    bus.direction = dir;
    bus.motion    = mot;
    bus.door_open = dopen;
    model_step(dir, mot, dopen);
    exp_q.push_back(model_out());
  endtask

  task automatic drive_n(input int n, input bit dir, input bit mot, input bit dopen);
    for (int i = 0; i < n; i++) drive(dir, mot, dopen);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.direction = 1'b0;
    bus.motion    = 1'b0;
    bus.door_open = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("floor_sense", 32'(bus.floor_sense), 32'(e.fs));
      chk("cur_floor",   32'(bus.cur_floor),   32'(e.cf));
      chk("moving",      32'(bus.moving),      32'(e.mv));
      chk("door_closed", 32'(bus.door_closed), 32'(e.dc));
      chk("door_full",   32'(bus.door_full),   32'(e.df));
      chk("fault",       32'(bus.fault),       32'(e.fl));
    end
  end

  initial begin
    bus.direction = 1'b0;
    bus.motion    = 1'b0;
    bus.door_open = 1'b0;
    model_reset();
    #12;
    // Reset values, checked directly while reset is held.
    chk("rst_floor_sense", 32'(bus.floor_sense), 32'h001);
    chk("rst_cur_floor",   32'(bus.cur_floor),   32'(RF));
    chk("rst_moving",      32'(bus.moving),      32'h0);
    chk("rst_door_closed", 32'(bus.door_closed), 32'h1);
    chk("rst_door_full",   32'(bus.door_full),   32'h0);
    chk("rst_fault",       32'(bus.fault),       32'h0);
    do_reset();

    // Single hop up, then idle.
    drive(1, 1, 0);
    drive_n(10, 1, 0, 0);

    // Three continuous hops, then stop.
    do_reset();
    drive_n(3 * (T + 1) - 1, 1, 1, 0);
    drive_n(12, 1, 0, 0);

    // Short door stroke: 1, 2, 1, 0.
    do_reset();
    drive_n(2, 0, 0, 1);
    drive_n(3, 0, 0, 0);

    // Door fully open, then motion request.
    drive_n(5, 0, 0, 1);
    drive_n(3, 1, 1, 1);
    drive_n(6, 0, 0, 0);

    // Down at floor 0.
    do_reset();
    drive_n(3, 0, 1, 0);

    // Climb to the top, then request up again.
    do_reset();
    drive_n(11 * (T + 1) + 3, 1, 1, 0);
    drive_n(2, 1, 0, 0);

    // Reset asserted on the 5th travel cycle snaps the car home immediately.
    do_reset();
    drive(1, 1, 0);
    drive_n(4, 1, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_floor_sense", 32'(bus.floor_sense), 32'h001);
    chk("async_moving",      32'(bus.moving),      32'h0);
    chk("async_door_closed", 32'(bus.door_closed), 32'h1);
    chk("async_cur_floor",   32'(bus.cur_floor),   32'h0);
    do_reset();
    drive_n(3, 0, 0, 0);

    // Randomised segments, each from reset.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < 500; i++)
        drive(1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < (s == 0 ? 3 : 20)));
    end

    drive_n(2, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_car_model.md
# lift_car_model

Behavioural-synthesisable plant model of one lift car, sitting on the far side of the multi-lift controller interface. It consumes the controller's per-car `direction`, `motion` and `door_open` commands and produces the car's one-hot `floor_sense` plus door and fault status, with finite travel and door times. One instance per car closes the loop for closed-loop simulation and FPGA demo builds.

## Interface
- `N_FLOORS`, 12, number of floors; must be at least 2.
- `TRAVEL_CYCLES`, 8, cycles between adjacent floors; must be at least 1.
- `DOOR_CYCLES`, 4, cycles for the door to go fully closed to fully open, and back.
- `RESET_FLOOR`, 0, floor index the car occupies after reset.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `direction`  in  1  commanded direction: 1 = up, 0 = down.
- `motion`  in  1  request to travel.
- `door_open`  in  1  request to open the door; 0 = request to close.
- `floor_sense`  out  N_FLOORS  one-hot current floor while stationary; all-zero while between floors.
- `cur_floor`  out  $clog2(N_FLOORS)  last floor reached, binary.
- `moving`  out  1  car is between floors.
- `door_closed`  out  1  door position is 0.
- `door_full`  out  1  door position is DOOR_CYCLES.
- `fault`  out  1  sticky protocol-violation flag.

## Operation
- States: `AT_FLOOR` and `TRAVEL`.
- Door position counter `dpos` runs 0..DOOR_CYCLES:
  - In `AT_FLOOR`, it increments per cycle while `door_open`=1 and decrements while 0, saturating at both ends.
  - A command reversal mid-stroke reverses immediately from the current position.
  - In `TRAVEL`, it holds at 0.
- `AT_FLOOR` → `TRAVEL` when `motion`=1, `dpos`=0, `door_open`=0, and the direction is legal:
  - Up is not legal at floor N_FLOORS-1; down is not legal at floor 0.
  - `direction` is latched at departure.
- `motion`=1 with the door not closed, or with an illegal direction: the car stays put and the fault condition is true.
- In `TRAVEL`, the travel counter counts 1..TRAVEL_CYCLES. On the cycle it reaches TRAVEL_CYCLES:
  - The state returns to `AT_FLOOR`.
  - `cur_floor` is updated by ±1 from the latched direction.
  - `floor_sense` is set to the new one-hot value.
- In `TRAVEL`, `direction` and `motion` changes are ignored. The car cannot stop between floors; dropping `motion` mid-travel still completes the hop.
- `door_open`=1 during `TRAVEL` is ignored and is a fault condition.
- Continuous travel: if `motion` is still 1 at arrival, the car departs again on the next edge. `floor_sense` is therefore valid for at least 1 cycle at every floor passed.

## Timing
- Reset values: state=`AT_FLOOR`, `dpos`=0, `cur_floor`=RESET_FLOOR, `floor_sense`=1<<RESET_FLOOR, `moving`=0, `door_closed`=1, `door_full`=0, `fault`=0.
- All outputs are registered.
- Departure: `motion` is sampled high at edge k. From edge k+1, `floor_sense`=0 and `moving`=1, for exactly TRAVEL_CYCLES cycles.
- Door: from closed, with `door_open` held high, `door_full` rises DOOR_CYCLES edges after the first high sample. Closing is symmetric.
- Fault is set on the edge after the condition is sampled. It clears only on reset.
- Reset asserted mid-travel: the car snaps to RESET_FLOOR asynchronously.

## Configuration
- `LIFT_MODEL_FAULT_EN` defined: fault detection and the sticky `fault` register are compiled in.
- Undefined: `fault` is tied 0. The interlocks are unchanged in both cases: no departure with the door open, no illegal direction, no door motion in `TRAVEL`.

## Structure
- Shared package `lift_pkg` holds:
  - `car_state_e` (`AT_FLOOR`, `TRAVEL`);
  - the direction encoding constants `DIR_UP`=1 and `DIR_DN`=0.
- Sub-module `lift_door_model` contains the `dpos` up/down saturating counter plus `door_closed`/`door_full` decode. It has an enable input that is low in `TRAVEL`.

## Test plan
All scenarios use defaults (N_FLOORS=12, TRAVEL_CYCLES=8, DOOR_CYCLES=4, RESET_FLOOR=0).
- Reset, then `motion`=1 and `direction`=1 for one cycle → `floor_sense`=0 for 8 cycles, then 12'h002, `cur_floor`=1, `fault`=0.
- `motion` and `direction`=1 held for 3 hops → `floor_sense` shows 12'h002, then 12'h004, then 12'h008, each for 1 cycle separated by 8-cycle gaps; the car stops at floor 3 after `motion` drops.
- `door_open`=1 for 2 cycles, then 0 → `dpos` goes 1, 2, 1, 0; `door_full` never rises; `door_closed` returns after 2 more cycles.
- Door fully open, then `motion`=1 → the car stays at floor 0 and `fault`=1 (0 with the macro undefined).
- At floor 0, `direction`=0 with `motion`=1 → no departure and `fault`=1. At floor 11, `direction`=1 → same response.
- Reset asserted on the 5th travel cycle → `floor_sense`=12'h001, `moving`=0 and `door_closed`=1 immediately, without waiting for a clock edge.
